// File: rtl/spwm_gate_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spwm_gate_monitor : per-phase duty/period measurement and shoot-through flag
// rev 1.0
// ---------------------------------------------------------------------------
module spwm_gate_monitor #(
   parameter int CNT_W  = 24,
   parameter int ST_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Va,
   input  logic             Van,
   input  logic             Vb,
   input  logic             Vbn,
   input  logic             Vc,
   input  logic             Vcn,
   output logic [CNT_W-1:0] duty_a,
   output logic [CNT_W-1:0] duty_b,
   output logic [CNT_W-1:0] duty_c,
   output logic [CNT_W-1:0] period_a,
   output logic [CNT_W-1:0] period_b,
   output logic [CNT_W-1:0] period_c,
   output logic             valid_a,
   output logic             valid_b,
   output logic             valid_c,
   output logic [2:0]       fault,
   output logic             fault_any
);

   localparam logic [1:0]       IDLE    = 2'd0;
   localparam logic [1:0]       HIGH    = 2'd1;
   localparam logic [1:0]       LOW     = 2'd2;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [3:0]       ST_THR  = 4'(ST_CYC);

   logic [2:0] raw_p, raw_n, meta_p, meta_n, sync_p, sync_n, prev_p;

   assign raw_p = {Vc, Vb, Va};
   assign raw_n = {Vcn, Vbn, Van};

   // Gate lines are asynchronous to clk: two-flop synchronizers, plus one
   // history flop on the high-side line for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_p <= '0;
         meta_n <= '0;
         sync_p <= '0;
         sync_n <= '0;
         prev_p <= '0;
      end else begin
         meta_p <= raw_p;
         meta_n <= raw_n;
         sync_p <= meta_p;
         sync_n <= meta_n;
         prev_p <= sync_p;
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_phase
      logic [1:0]       state, state_nxt;
      logic [CNT_W-1:0] hi_cnt, per_cnt, duty, period;
      logic             valid, flt, sx, rise, fall, per_sat, start, latch;
      logic [3:0]       st_cnt;

      assign sx      = sync_p[i];
      assign rise    = sx & ~prev_p[i];
      assign fall    = ~sx & prev_p[i];
      assign per_sat = (per_cnt == CNT_MAX);

      always_ff @(posedge clk) begin
         if (rst) state <= IDLE;
         else     state <= state_nxt;
      end

      // A saturated period counter means the line stopped toggling; a rise
      // coinciding with that is treated as a fresh start, never a latch.
      always_comb begin
         state_nxt = state;
         case (state)
            IDLE:    if (rise) state_nxt = HIGH;
            HIGH:    if (per_sat)   state_nxt = rise ? HIGH : IDLE;
                     else if (fall) state_nxt = LOW;
            LOW:     if (per_sat)   state_nxt = rise ? HIGH : IDLE;
                     else if (rise) state_nxt = HIGH;
            default: state_nxt = IDLE;
         endcase
      end

      always_comb begin
         start = 1'b0;
         latch = 1'b0;
         case (state)
            IDLE:      start = rise;
            HIGH, LOW: if (per_sat) start = rise;
                       else         latch = (state == LOW) && rise;
            default:   ;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
         end else if (start || latch) begin
            hi_cnt  <= CNT_ONE;
            per_cnt <= CNT_ONE;
         end else if (state_nxt == IDLE) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
         end else begin
            if (!per_sat) per_cnt <= per_cnt + CNT_ONE;
            if ((state == HIGH) && sx && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CNT_ONE;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            duty   <= '0;
            period <= '0;
            valid  <= 1'b0;
         end else begin
            valid <= latch;
            if (latch) begin
               duty   <= hi_cnt;
               period <= per_cnt;
            end
         end
      end

      // Both-low dead time simply clears the overlap counter.
      always_ff @(posedge clk) begin
         if (rst) begin
            st_cnt <= '0;
            flt    <= 1'b0;
         end else begin
            if (sync_p[i] & sync_n[i]) st_cnt <= (st_cnt == 4'hF) ? st_cnt : st_cnt + 4'd1;
            else                       st_cnt <= '0;
            if (st_cnt >= ST_THR) flt <= 1'b1;
         end
      end
   end

   assign duty_a   = g_phase[0].duty;
   assign duty_b   = g_phase[1].duty;
   assign duty_c   = g_phase[2].duty;
   assign period_a = g_phase[0].period;
   assign period_b = g_phase[1].period;
   assign period_c = g_phase[2].period;
   assign valid_a  = g_phase[0].valid;
   assign valid_b  = g_phase[1].valid;
   assign valid_c  = g_phase[2].valid;
   assign fault    = {g_phase[2].flt, g_phase[1].flt, g_phase[0].flt};

   always_ff @(posedge clk) begin
      if (rst) fault_any <= 1'b0;
      else     fault_any <= |fault;
   end

endmodule
`default_nettype wire
